// File: rtl/uc_pkg.sv
// Shared encodings for the multicycle control unit: states, opcodes, datapath selects.
package uc_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned SEL_W    = 2;

  typedef logic [STATE_W-1:0]  state_t;
  typedef logic [OPCODE_W-1:0] opcode_t;

  localparam state_t S_FETCH     = 4'd0;
  localparam state_t S_DECODE    = 4'd1;
  localparam state_t S_MEM_ADDR  = 4'd2;
  localparam state_t S_MEM_READ  = 4'd3;
  localparam state_t S_MEM_WB    = 4'd4;
  localparam state_t S_MEM_WRITE = 4'd5;
  localparam state_t S_EXEC_R    = 4'd6;
  localparam state_t S_ALU_WB    = 4'd7;
  localparam state_t S_EXEC_I    = 4'd8;
  localparam state_t S_BRANCH    = 4'd9;
  localparam state_t S_JAL       = 4'd10;
  localparam state_t S_HALT      = 4'd11;

  localparam opcode_t OP_LOAD   = 7'b0000011;
  localparam opcode_t OP_STORE  = 7'b0100011;
  localparam opcode_t OP_RTYPE  = 7'b0110011;
  localparam opcode_t OP_ITYPE  = 7'b0010011;
  localparam opcode_t OP_BRANCH = 7'b1100011;
  localparam opcode_t OP_JAL    = 7'b1101111;

  // aluOp values understood by alu_uc
  localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [SEL_W-1:0] ALUOP_ITYPE = 2'b01;
  localparam logic [SEL_W-1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [SEL_W-1:0] SRCB_REG  = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b10;

  localparam logic [SEL_W-1:0] M2R_ALUOUT = 2'b00;
  localparam logic [SEL_W-1:0] M2R_MDR    = 2'b01;
  localparam logic [SEL_W-1:0] M2R_PC     = 2'b10;

  // One-hot instruction class
  typedef struct packed {
    logic load;
    logic store;
    logic rtype;
    logic itype;
    logic btype;
    logic jal;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/multicycle_uc_opcode_class.sv
// Opcode classifier, shared with hazard/debug logic.
module opcode_class
  import uc_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output op_class_t           cls_c
);

  // Decode opcode into a one-hot class; anything unknown is illegal
  always_comb begin
    cls_c         = '0;
    cls_c.load    = (opcode == OP_LOAD);
    cls_c.store   = (opcode == OP_STORE);
    cls_c.rtype   = (opcode == OP_RTYPE);
    cls_c.itype   = (opcode == OP_ITYPE);
    cls_c.btype   = (opcode == OP_BRANCH);
    cls_c.jal     = (opcode == OP_JAL);
    cls_c.illegal = !(cls_c.load || cls_c.store || cls_c.rtype ||
                      cls_c.itype || cls_c.btype || cls_c.jal);
  end

endmodule

// File: rtl/multicycle_uc.sv
// Main control unit of the multicycle RV32I-subset core.
module multicycle_uc
  import uc_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                branch,
  input  logic                mem_ready,
  output logic                pcWrite,
  output logic                irWrite,
  output logic                iOrD,
  output logic                memRead,
  output logic                memWrite,
  output logic                regWrite,
  output logic [SEL_W-1:0]    memToReg,
  output logic                aluSrcA,
  output logic [SEL_W-1:0]    aluSrcB,
  output logic [SEL_W-1:0]    aluOp,
  output logic                pcSrc,
  output logic                halted,
  output logic [STATE_W-1:0]  state
);

  state_t    state_q;
  state_t    state_nxt;
  op_class_t cls;

  opcode_class u_opcode_class (
    .opcode (opcode),
    .cls_c  (cls)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_nxt;
  end

  // Next state and datapath controls; everything is forced low while in reset
  always_comb begin
    state_nxt = state_q;
    pcWrite   = 1'b0;
    irWrite   = 1'b0;
    iOrD      = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    regWrite  = 1'b0;
    memToReg  = M2R_ALUOUT;
    aluSrcA   = 1'b0;
    aluSrcB   = SRCB_REG;
    aluOp     = ALUOP_ADD;
    pcSrc     = 1'b0;
    halted    = 1'b0;
    state     = state_q;

    case (state_q)
      S_FETCH: begin
        memRead = 1'b1;
        aluSrcB = SRCB_FOUR;
        if (mem_ready) begin
          irWrite   = 1'b1;
          pcWrite   = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        aluSrcB = SRCB_IMM;
        if (cls.illegal)                 state_nxt = S_HALT;
        else if (cls.load || cls.store)  state_nxt = S_MEM_ADDR;
        else if (cls.rtype)              state_nxt = S_EXEC_R;
        else if (cls.itype)              state_nxt = S_EXEC_I;
        else if (cls.btype)              state_nxt = S_BRANCH;
        else if (cls.jal)                state_nxt = S_JAL;
        else                             state_nxt = S_HALT;
      end
      S_MEM_ADDR: begin
        aluSrcA   = 1'b1;
        aluSrcB   = SRCB_IMM;
        state_nxt = cls.load ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        memRead = 1'b1;
        iOrD    = 1'b1;
        if (mem_ready) state_nxt = S_MEM_WB;
      end
      S_MEM_WB: begin
        regWrite  = 1'b1;
        memToReg  = M2R_MDR;
        state_nxt = S_FETCH;
      end
      S_MEM_WRITE: begin
        memWrite = 1'b1;
        iOrD     = 1'b1;
        if (mem_ready) state_nxt = S_FETCH;
      end
      S_EXEC_R: begin
        aluSrcA   = 1'b1;
        aluOp     = ALUOP_RTYPE;
        state_nxt = S_ALU_WB;
      end
      S_EXEC_I: begin
        aluSrcA   = 1'b1;
        aluSrcB   = SRCB_IMM;
        aluOp     = ALUOP_ITYPE;
        state_nxt = S_ALU_WB;
      end
      S_ALU_WB: begin
        regWrite  = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        aluSrcA   = 1'b1;
        pcSrc     = 1'b1;
        pcWrite   = branch;
        state_nxt = S_FETCH;
      end
      S_JAL: begin
        regWrite  = 1'b1;
        memToReg  = M2R_PC;
        pcWrite   = 1'b1;
        pcSrc     = 1'b1;
        state_nxt = S_FETCH;
      end
      // HALT and the unused encodings park the core until reset
      default: begin
        halted    = 1'b1;
        state_nxt = S_HALT;
      end
    endcase

    if (reset) begin
      pcWrite  = 1'b0;
      irWrite  = 1'b0;
      iOrD     = 1'b0;
      memRead  = 1'b0;
      memWrite = 1'b0;
      regWrite = 1'b0;
      memToReg = '0;
      aluSrcA  = 1'b0;
      aluSrcB  = '0;
      aluOp    = '0;
      pcSrc    = 1'b0;
      halted   = 1'b0;
      state    = '0;
    end
  end

endmodule

// File: tb/tb_multicycle_uc.sv
// Bench for multicycle_uc: per-cycle expected state/controls queued at drive time, checked mid-cycle.
module tb_multicycle_uc;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       branch;
  logic       mem_ready;
  logic       pcWrite, irWrite, iOrD, memRead, memWrite, regWrite;
  logic [1:0] memToReg, aluSrcB, aluOp;
  logic       aluSrcA, pcSrc, halted;
  logic [3:0] state;

  int total = 0;
  int bad   = 0;
  string tname;
  int    cyc;

  typedef struct packed {
    logic [3:0]  st;
    logic [14:0] o;
  } exp_t;
  exp_t exp_q[$];

  logic [14:0] obs;
  assign obs = {halted, pcSrc, aluOp, aluSrcB, aluSrcA, memToReg,
                regWrite, memWrite, memRead, iOrD, irWrite, pcWrite};

  multicycle_uc dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .branch    (branch),
    .mem_ready (mem_ready),
    .pcWrite   (pcWrite),
    .irWrite   (irWrite),
    .iOrD      (iOrD),
    .memRead   (memRead),
    .memWrite  (memWrite),
    .regWrite  (regWrite),
    .memToReg  (memToReg),
    .aluSrcA   (aluSrcA),
    .aluSrcB   (aluSrcB),
    .aluOp     (aluOp),
    .pcSrc     (pcSrc),
    .halted    (halted),
    .state     (state)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] ov(input logic pcw, irw, iord, mr, mw, rw,
                                     input logic [1:0] m2r, input logic sa,
                                     input logic [1:0] sb, aop,
                                     input logic ps, h);
    return {h, ps, aop, sb, sa, m2r, rw, mw, mr, iord, irw, pcw};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, compare at the falling edge
  task automatic step(input logic rst, mr, br, input logic [3:0] est, input logic [14:0] eo);
    exp_t e;
    reset     = rst;
    mem_ready = mr;
    branch    = br;
    exp_q.push_back('{st: est, o: eo});
    @(negedge clk);
    e = exp_q.pop_front();
    check($sformatf("%s.c%0d.state", tname, cyc), 32'(state), 32'(e.st));
    check($sformatf("%s.c%0d.ctrl", tname, cyc), 32'(obs), 32'(e.o));
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic start(input string n, input logic [6:0] op);
    tname  = n;
    cyc    = 1;
    opcode = op;
  endtask

  logic [14:0] o_zero, o_fw, o_fr, o_dec, o_madr, o_mrd, o_mwb, o_mwr;
  logic [14:0] o_exr, o_exi, o_awb, o_bnt, o_bt, o_jal, o_halt;

  initial begin
    o_zero = '0;
    o_fw   = ov(0,0,0,1,0,0, 2'b00, 0, 2'b01, 2'b00, 0, 0);
    o_fr   = ov(1,1,0,1,0,0, 2'b00, 0, 2'b01, 2'b00, 0, 0);
    o_dec  = ov(0,0,0,0,0,0, 2'b00, 0, 2'b10, 2'b00, 0, 0);
    o_madr = ov(0,0,0,0,0,0, 2'b00, 1, 2'b10, 2'b00, 0, 0);
    o_mrd  = ov(0,0,1,1,0,0, 2'b00, 0, 2'b00, 2'b00, 0, 0);
    o_mwb  = ov(0,0,0,0,0,1, 2'b01, 0, 2'b00, 2'b00, 0, 0);
    o_mwr  = ov(0,0,1,0,1,0, 2'b00, 0, 2'b00, 2'b00, 0, 0);
    o_exr  = ov(0,0,0,0,0,0, 2'b00, 1, 2'b00, 2'b10, 0, 0);
    o_exi  = ov(0,0,0,0,0,0, 2'b00, 1, 2'b10, 2'b01, 0, 0);
    o_awb  = ov(0,0,0,0,0,1, 2'b00, 0, 2'b00, 2'b00, 0, 0);
    o_bnt  = ov(0,0,0,0,0,0, 2'b00, 1, 2'b00, 2'b00, 1, 0);
    o_bt   = ov(1,0,0,0,0,0, 2'b00, 1, 2'b00, 2'b00, 1, 0);
    o_jal  = ov(1,0,0,0,0,1, 2'b10, 0, 2'b00, 2'b00, 1, 0);
    o_halt = ov(0,0,0,0,0,0, 2'b00, 0, 2'b00, 2'b00, 0, 1);

    reset = 1'b1; mem_ready = 1'b1; branch = 1'b0; opcode = 7'h00;
    @(posedge clk);
    #1;

    start("reset", 7'h00);
    step(1, 1, 1, 4'd0, o_zero);

    // add, branch held high to show it is ignored outside BRANCH
    start("add", 7'b0110011);
    step(0, 1, 1, 4'd0, o_fr);
    step(0, 0, 1, 4'd1, o_dec);
    step(0, 0, 1, 4'd6, o_exr);
    step(0, 0, 1, 4'd7, o_awb);

    // lw with two fetch waits and one read wait
    start("lw", 7'b0000011);
    step(0, 0, 0, 4'd0, o_fw);
    step(0, 0, 0, 4'd0, o_fw);
    step(0, 1, 0, 4'd0, o_fr);
    step(0, 1, 0, 4'd1, o_dec);
    step(0, 1, 0, 4'd2, o_madr);
    step(0, 0, 0, 4'd3, o_mrd);
    step(0, 1, 0, 4'd3, o_mrd);
    step(0, 1, 0, 4'd4, o_mwb);

    start("beq_nt", 7'b1100011);
    step(0, 1, 0, 4'd0, o_fr);
    step(0, 1, 1, 4'd1, o_dec);
    step(0, 1, 0, 4'd9, o_bnt);

    start("beq_t", 7'b1100011);
    step(0, 1, 0, 4'd0, o_fr);
    step(0, 1, 0, 4'd1, o_dec);
    step(0, 1, 1, 4'd9, o_bt);

    start("jal", 7'b1101111);
    step(0, 1, 0, 4'd0, o_fr);
    step(0, 1, 0, 4'd1, o_dec);
    step(0, 1, 0, 4'd10, o_jal);

    start("addi", 7'b0010011);
    step(0, 1, 0, 4'd0, o_fr);
    step(0, 1, 0, 4'd1, o_dec);
    step(0, 1, 0, 4'd8, o_exi);
    step(0, 1, 0, 4'd7, o_awb);

    start("sw", 7'b0100011);
    step(0, 1, 0, 4'd0, o_fr);
    step(0, 1, 0, 4'd1, o_dec);
    step(0, 1, 0, 4'd2, o_madr);
    step(0, 1, 0, 4'd5, o_mwr);

    // illegal opcode parks the core; random inputs must not wake it
    start("halt", 7'b1111111);
    step(0, 1, 0, 4'd0, o_fr);
    step(0, 1, 0, 4'd1, o_dec);
    for (int i = 0; i < 20; i++)
      step(0, 1'($urandom_range(1)), 1'($urandom_range(1)), 4'd11, o_halt);
    step(1, 1, 1, 4'd0, o_zero);
    step(0, 1, 0, 4'd0, o_fr);

    // reset lands while a store waits on memory
    start("sw_rst", 7'b0100011);
    step(0, 1, 0, 4'd1, o_dec);
    step(0, 1, 0, 4'd2, o_madr);
    step(0, 0, 0, 4'd5, o_mwr);
    step(0, 0, 0, 4'd5, o_mwr);
    step(1, 0, 0, 4'd0, o_zero);
    step(0, 0, 0, 4'd0, o_fw);
    step(0, 1, 0, 4'd0, o_fr);
    step(0, 1, 0, 4'd1, o_dec);
    step(0, 1, 0, 4'd2, o_madr);
    step(0, 1, 0, 4'd5, o_mwr);
    step(0, 1, 0, 4'd0, o_fr);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_uc.md
# multicycle_uc

Main control unit for the multicycle RV32I-subset core. It sequences the shared datapath (PC, IR, register file, single ALU, unified memory) through fetch, decode, execute, memory and write-back states. It drives `aluOp` into `alu_uc` and consumes its `branch` output. It supports R-type (add/sub/and/or/xor), addi, lw, sw, beq/bne/blt/bgt and jal, and waits on a memory-ready handshake.

## Interface
- No parameters. Encodings are fixed package constants.
- `clk`  in  1  single system clock, rising edge
- `reset`  in  1  synchronous, active-high
- `opcode`  in  7  IR[6:0], valid from DECODE onward
- `branch`  in  1  branch-taken from `alu_uc`, valid in BRANCH
- `mem_ready`  in  1  memory completes the current read/write this cycle
- `pcWrite`  out  1  load PC
- `irWrite`  out  1  load IR from memory read data
- `iOrD`  out  1  memory address: 0 = PC, 1 = ALUOut
- `memRead`  out  1  memory read request
- `memWrite`  out  1  memory write request
- `regWrite`  out  1  register file write of rd
- `memToReg`  out  2  rd source: 00 ALUOut, 01 MDR, 10 PC
- `aluSrcA`  out  1  0 = PC, 1 = A register
- `aluSrcB`  out  2  00 = B register, 01 = const 4, 10 = immediate
- `aluOp`  out  2  00 add, 01 I-type, 10 R-type (to `alu_uc`)
- `pcSrc`  out  1  0 = ALU result, 1 = ALUOut
- `halted`  out  1  illegal opcode seen; core stopped
- `state`  out  4  current state, for debug and bench

## Operation
- Outputs are combinational from `state`, `mem_ready` and `branch`. Any output not listed for a state is 0, and `aluOp` = 00.
- FETCH (0): memRead=1, iOrD=0, aluSrcA=0, aluSrcB=01. If mem_ready: irWrite=1, pcWrite=1, pcSrc=0, go to DECODE. Otherwise stay.
- DECODE (1): aluSrcA=0, aluSrcB=10 (ALUOut <= oldPC+4+imm path; the target is computed from the PC latched in the datapath). Next state by opcode:
  - 0000011 or 0100011 -> MEM_ADDR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - anything else -> HALT
- MEM_ADDR (2): aluSrcA=1, aluSrcB=10, aluOp=00. Go to MEM_READ if opcode is lw, else MEM_WRITE.
- MEM_READ (3): memRead=1, iOrD=1. Hold until mem_ready, then go to MEM_WB.
- MEM_WB (4): regWrite=1, memToReg=01. Go to FETCH.
- MEM_WRITE (5): memWrite=1, iOrD=1. Hold until mem_ready, then go to FETCH.
- EXEC_R (6): aluSrcA=1, aluSrcB=00, aluOp=10. Go to ALU_WB.
- EXEC_I (8): aluSrcA=1, aluSrcB=10, aluOp=01. Go to ALU_WB.
- ALU_WB (7): regWrite=1, memToReg=00. Go to FETCH.
- BRANCH (9): aluSrcA=1, aluSrcB=00, aluOp=00, pcSrc=1, pcWrite=branch. Go to FETCH.
- JAL (10): regWrite=1, memToReg=10 (PC already holds pc+4), pcWrite=1, pcSrc=1. Go to FETCH.
- HALT (11): halted=1 and all strobes 0. Only reset leaves this state.
- Encodings 12–15 are unreachable. If entered, treat as HALT.

## Timing
- Reset: state=FETCH on the next rising edge. During reset all outputs are forced to 0, including memRead and halted, regardless of state.
- Reset mid-instruction aborts it; no write strobe is asserted in the reset cycle.
- Cycle counts with zero wait (mem_ready always 1):
  - lw: 5
  - sw, R-type, addi: 4
  - beq/bne/blt/bgt, jal: 3
- Each cycle mem_ready is low in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle. memRead/memWrite and iOrD stay stable while waiting.
- irWrite and pcWrite in FETCH assert for exactly one cycle: the mem_ready cycle.
- mem_ready outside the three memory states is ignored.
- `branch` is sampled only in BRANCH. A not-taken branch produces no pcWrite pulse.

## Structure
- Package `uc_pkg`:
  - state localparams (4-bit)
  - opcode constants
  - aluOp constants matching `alu_uc` (00/01/10)
  - aluSrcB and memToReg select constants
- One register (`state`) with a next-state case block and an output case block.
- Optional sub-module `opcode_class`: maps opcode to a one-hot {load, store, rtype, itype, btype, jal, illegal}. It is shared with the later hazard/debug logic.

## Test plan
- add (0110011), mem_ready=1: states 0,1,6,7,0. aluOp=10 in cycle 3, regWrite pulses in cycle 4 only.
- lw, mem_ready low 2 cycles in FETCH and 1 cycle in MEM_READ: 8 cycles total. irWrite pulses once, regWrite with memToReg=01 once.
- beq with branch=0: 3 cycles, no pcWrite in BRANCH. Repeat with branch=1: pcWrite=1, pcSrc=1 in cycle 3.
- jal: regWrite with memToReg=10 and pcWrite with pcSrc=1 in the same cycle (cycle 3).
- Opcode 1111111: HALT after DECODE, halted=1 held for 20 cycles, no strobes. Reset returns to FETCH.
- Reset asserted during MEM_WRITE wait: memWrite=0 in the reset cycle, state=0 next cycle, then a normal fetch.
